// File: rtl/br_resolve_pkg.sv
// Shared LC-3b types for branch resolution: words, control-flow opcodes and
// the prediction record carried from fetch to writeback.
package br_resolve_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  localparam lc3b_opcode op_br   = 4'b0000;
  localparam lc3b_opcode op_jmp  = 4'b1100;
  localparam lc3b_opcode op_jsr  = 4'b0100;
  localparam lc3b_opcode op_trap = 4'b1111;

  typedef struct packed {
    lc3b_word pc;
    logic     hit;
    lc3b_word target;
  } pred_entry_t;

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} br_state_e;

  function automatic logic is_ctrl(lc3b_opcode op);
    return (op == op_br) || (op == op_jmp) || (op == op_jsr) || (op == op_trap);
  endfunction
endpackage

// File: rtl/br_resolve_fifo.sv
// In-order prediction queue: circular buffer with push/pop/clear and occupancy.
// Callers never push when full without popping, nor pop when empty.
module pred_fifo
  import br_resolve_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  pred_entry_t              wdata_i,
  output pred_entry_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  pred_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/br_resolve.sv
// Branch resolution: compares each retiring instruction's predicted next PC
// with its real one and issues a registered one-cycle flush on mismatch.
module br_resolve
  import br_resolve_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_push,
  input  logic [15:0]      pred_pc,
  input  logic             pred_hit,
  input  logic [15:0]      pred_target,
  input  logic             is_valid_inst_wb,
  input  logic [15:0]      pc_wb,
  input  logic [3:0]       opcode_wb,
  input  logic             br_taken_wb,
  input  logic [15:0]      alu_out_wb,
  input  logic [15:0]      mem_wb,
  output logic             flush,
  output logic [15:0]      redirect_pc,
  output logic             queue_full,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             err_sync,
  output logic             err_ovf,
  output logic             err_udf
);
  localparam int CW = $clog2(DEPTH) + 1;

  br_state_e        state_q, state_d;
  pred_entry_t      head, wentry;
  logic [CW-1:0]    count;
  logic             run, empty, wb_pop, push_ok, mis, sync_bad;
  lc3b_word         act_npc, pred_npc, redirect_q;
  logic [CNT_W-1:0] branch_q, mis_q;
  logic             err_sync_q, err_ovf_q, err_udf_q;

  assign run        = (state_q == S_RUN);
  assign empty      = (count == '0);
  assign queue_full = (count == CW'(DEPTH));
  assign wb_pop     = run && is_valid_inst_wb && !empty;
  // A same-cycle pop frees the slot, so a push at full is still accepted.
  assign push_ok    = run && pred_push && (!queue_full || wb_pop);
  assign wentry     = '{pc: pred_pc, hit: pred_hit, target: pred_target};

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .pop_i   (wb_pop),
    .clear_i (mis),
    .wdata_i (wentry),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    act_npc = pc_wb + 16'd2;
    case (opcode_wb)
      op_trap:        act_npc = mem_wb;
      op_jmp, op_jsr: act_npc = alu_out_wb;
      op_br:          if (br_taken_wb) act_npc = alu_out_wb;
      default:        ;
    endcase
  end

  assign pred_npc = head.hit ? head.target : head.pc + 16'd2;
  assign sync_bad = (head.pc != pc_wb);
  assign mis      = wb_pop && (sync_bad || (pred_npc != act_npc));

  always_comb begin
    state_d = S_RUN;
    if (run && mis) state_d = S_FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      redirect_q <= '0;
      branch_q   <= '0;
      mis_q      <= '0;
      err_sync_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mis) redirect_q <= act_npc;
      if (wb_pop && is_ctrl(opcode_wb) && (branch_q != '1))
        branch_q <= branch_q + CNT_W'(1);
      if (mis && (mis_q != '1)) mis_q <= mis_q + CNT_W'(1);
      if (wb_pop && sync_bad) err_sync_q <= 1'b1;
      if (run && pred_push && queue_full && !wb_pop) err_ovf_q <= 1'b1;
      if (run && is_valid_inst_wb && empty) err_udf_q <= 1'b1;
    end
  end

  assign flush            = (state_q == S_FLUSH);
  assign redirect_pc      = redirect_q;
  assign branch_count     = branch_q;
  assign mispredict_count = mis_q;
  assign err_sync         = err_sync_q;
  assign err_ovf          = err_ovf_q;
  assign err_udf          = err_udf_q;
endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve with a queue-based reference model checked
// every cycle, plus literal expectations at key points.
module tb_br_resolve;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam logic [3:0] BR = 4'b0000, JMP = 4'b1100, TRAP = 4'b1111, ADD = 4'b0001;

  logic clk, rst_n;
  logic pred_push, pred_hit, is_valid_inst_wb, br_taken_wb;
  logic [15:0] pred_pc, pred_target, pc_wb, alu_out_wb, mem_wb;
  logic [3:0] opcode_wb;
  logic flush, queue_full, err_sync, err_ovf, err_udf;
  logic [15:0] redirect_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  br_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_push(pred_push), .pred_pc(pred_pc), .pred_hit(pred_hit), .pred_target(pred_target),
    .is_valid_inst_wb(is_valid_inst_wb), .pc_wb(pc_wb), .opcode_wb(opcode_wb),
    .br_taken_wb(br_taken_wb), .alu_out_wb(alu_out_wb), .mem_wb(mem_wb),
    .flush(flush), .redirect_pc(redirect_pc), .queue_full(queue_full),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .err_sync(err_sync), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of predictions plus observable state.
  typedef struct {logic [15:0] pc; bit hit; logic [15:0] tgt;} ment_t;
  ment_t       mq[$];
  bit          m_flush, m_sync, m_ovf, m_udf;
  logic [15:0] m_redir;
  int          m_bc, m_mc;

  function automatic void mreset();
    mq.delete();
    m_flush = 0; m_sync = 0; m_ovf = 0; m_udf = 0;
    m_redir = 16'h0; m_bc = 0; m_mc = 0;
  endfunction

  function automatic void mstep();
    bit was_full, popped, bad;
    ment_t e;
    logic [15:0] act, pred;
    if (m_flush) begin
      m_flush = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    popped = 0; bad = 0; act = 16'h0;
    if (is_valid_inst_wb) begin
      if (mq.size() == 0) m_udf = 1;
      else begin
        e = mq.pop_front();
        popped = 1;
        if (opcode_wb == TRAP) act = mem_wb;
        else if (opcode_wb == JMP || opcode_wb == 4'b0100) act = alu_out_wb;
        else if (opcode_wb == BR && br_taken_wb) act = alu_out_wb;
        else act = pc_wb + 16'd2;
        pred = e.hit ? e.tgt : e.pc + 16'd2;
        if (opcode_wb inside {BR, JMP, 4'b0100, TRAP} && m_bc < 65535) m_bc++;
        if (e.pc != pc_wb) begin m_sync = 1; bad = 1; end
        if (pred != act) bad = 1;
      end
    end
    if (pred_push) begin
      if (was_full && !popped) m_ovf = 1;
      else mq.push_back('{pred_pc, pred_hit, pred_target});
    end
    if (bad) begin
      mq.delete();
      m_flush = 1;
      m_redir = act;
      if (m_mc < 65535) m_mc++;
    end
  endfunction

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else if (clk) mstep();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) mreset();
      chk("flush", flush, m_flush);
      if (m_flush) chk("redirect_pc", redirect_pc, m_redir);
      chk("queue_full", queue_full, mq.size() == DEPTH);
      chk("branch_count", branch_count, m_bc);
      chk("mispredict_count", mispredict_count, m_mc);
      chk("err_sync", err_sync, m_sync);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_udf", err_udf, m_udf);
    end
  end

  task automatic cyc(input bit push, input logic [15:0] ppc, input bit hit, input logic [15:0] tgt,
                     input bit wbv, input logic [15:0] pcw, input logic [3:0] op, input bit tk,
                     input logic [15:0] alu, input logic [15:0] mem);
    pred_push = push; pred_pc = ppc; pred_hit = hit; pred_target = tgt;
    is_valid_inst_wb = wbv; pc_wb = pcw; opcode_wb = op; br_taken_wb = tk;
    alu_out_wb = alu; mem_wb = mem;
    @(negedge clk);
  endtask

  task automatic push_only(input logic [15:0] ppc, input bit hit, input logic [15:0] tgt);
    cyc(1, ppc, hit, tgt, 0, 16'h0, ADD, 0, 16'h0, 16'h0);
  endtask

  task automatic wb_only(input logic [15:0] pcw, input logic [3:0] op, input bit tk,
                         input logic [15:0] alu, input logic [15:0] mem);
    cyc(0, 16'h0, 0, 16'h0, 1, pcw, op, tk, alu, mem);
  endtask

  task automatic idle();
    cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, ADD, 0, 16'h0, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    pred_push = 0; pred_pc = 0; pred_hit = 0; pred_target = 0;
    is_valid_inst_wb = 0; pc_wb = 0; opcode_wb = ADD; br_taken_wb = 0;
    alu_out_wb = 0; mem_wb = 0;
    repeat (2) @(negedge clk);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 16'h0000);
    chk("rst_full", queue_full, 0);
    rst_n = 1'b1;
    idle();

    // Correctly predicted taken BR
    push_only(16'h3000, 1, 16'h3010);
    wb_only(16'h3000, BR, 1, 16'h3010, 16'h0);
    chk("br_ok_flush", flush, 0);
    chk("br_ok_bc", branch_count, 1);
    chk("br_ok_mc", mispredict_count, 0);

    // BTB miss on taken BR; the WB in the flush cycle is ignored
    push_only(16'h3000, 0, 16'h0);
    wb_only(16'h3000, BR, 1, 16'h3040, 16'h0);
    chk("miss_flush", flush, 1);
    chk("miss_redirect", redirect_pc, 16'h3040);
    cyc(1, 16'h7000, 1, 16'h7777, 1, 16'h1234, JMP, 0, 16'h9999, 16'h0);
    chk("miss_flush_end", flush, 0);
    chk("miss_bc", branch_count, 2);
    chk("miss_mc", mispredict_count, 1);
    chk("miss_no_udf", err_udf, 0);

    // Stale hit on a non-control instruction
    push_only(16'h4000, 1, 16'h5000);
    wb_only(16'h4000, ADD, 0, 16'h0, 16'h0);
    chk("stale_flush", flush, 1);
    chk("stale_redirect", redirect_pc, 16'h4002);
    chk("stale_bc", branch_count, 2);
    idle();

    // TRAP resolves via mem_wb, not alu_out_wb
    push_only(16'h2000, 1, 16'h0400);
    wb_only(16'h2000, TRAP, 0, 16'h1234, 16'h0400);
    chk("trap_flush", flush, 0);
    chk("trap_bc", branch_count, 3);

    // PC+2 wraps at the top of the address space
    push_only(16'hFFFE, 0, 16'h0);
    wb_only(16'hFFFE, ADD, 0, 16'h0, 16'h0);
    chk("wrap_flush", flush, 0);

    // Fill, simultaneous push+pop at full, overflow, drain
    for (int i = 0; i < DEPTH; i++) push_only(16'h6000 + 16'(2*i), 0, 16'h0);
    chk("fill_full", queue_full, 1);
    cyc(1, 16'h6010, 0, 16'h0, 1, 16'h6000, ADD, 0, 16'h0, 16'h0);
    chk("pp_full", queue_full, 1);
    chk("pp_no_ovf", err_ovf, 0);
    push_only(16'h6012, 0, 16'h0);
    chk("ovf_set", err_ovf, 1);
    chk("ovf_full", queue_full, 1);
    for (int i = 0; i < DEPTH; i++) wb_only(16'h6002 + 16'(2*i), ADD, 0, 16'h0, 16'h0);
    chk("drain_full", queue_full, 0);
    chk("drain_no_flush", flush, 0);

    // Retire with an empty queue
    wb_only(16'h1000, ADD, 0, 16'h0, 16'h0);
    chk("udf_set", err_udf, 1);
    chk("udf_no_flush", flush, 0);

    // Head PC out of sync with WB PC
    push_only(16'h3000, 0, 16'h0);
    wb_only(16'h3002, ADD, 0, 16'h0, 16'h0);
    chk("sync_set", err_sync, 1);
    chk("sync_flush", flush, 1);
    chk("sync_redirect", redirect_pc, 16'h3004);
    idle();

    // Reset asserted in the middle of a flush pulse
    push_only(16'h3000, 0, 16'h0);
    wb_only(16'h3000, BR, 1, 16'h3100, 16'h0);
    chk("pre_rst_flush", flush, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_redirect", redirect_pc, 16'h0000);
    chk("mid_rst_bc", branch_count, 0);
    chk("mid_rst_mc", mispredict_count, 0);
    chk("mid_rst_errs", {err_sync, err_ovf, err_udf}, 3'b000);
    chk("mid_rst_full", queue_full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Normal operation resumes after reset
    push_only(16'h3000, 1, 16'h2F00);
    wb_only(16'h3000, BR, 1, 16'h2F00, 16'h0);
    chk("post_rst_bc", branch_count, 1);
    chk("post_rst_flush", flush, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
